// File: rtl/cpu_fetch_decode_pkg.sv
// Shared definitions for the MCS8 fetch/decode front end:
// instruction class codes, assembler states, length encoding, opcode classifier.
package cpu_fetch_decode_pkg;

    typedef enum logic [4:0] {
        CLS_NOP     = 5'd0,
        CLS_HLT     = 5'd1,
        CLS_INC     = 5'd2,
        CLS_DCR     = 5'd3,
        CLS_ROT     = 5'd4,
        CLS_RETC    = 5'd5,
        CLS_ALUI    = 5'd6,
        CLS_RST     = 5'd7,
        CLS_LRI     = 5'd8,
        CLS_LMI     = 5'd9,
        CLS_RET     = 5'd10,
        CLS_JMPC    = 5'd11,
        CLS_CALC    = 5'd12,
        CLS_JMP     = 5'd13,
        CLS_CAL     = 5'd14,
        CLS_INP     = 5'd15,
        CLS_OUT     = 5'd16,
        CLS_ALUR    = 5'd17,
        CLS_ALUM    = 5'd18,
        CLS_LRR     = 5'd19,
        CLS_LRM     = 5'd20,
        CLS_LMR     = 5'd21,
        CLS_ILLEGAL = 5'd31
    } inst_class_t;

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_B2   = 2'd1,
        S_B3   = 2'd2,
        S_HALT = 2'd3
    } asm_state_t;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    // Decode an opcode byte into its class; undefined encodings fold to NOP
    // when illegal reporting is disabled.
    function automatic inst_class_t classify(input logic [7:0] op, input logic illegal_en);
        inst_class_t cls;
        logic [2:0]  hi;
        logic [2:0]  lo;
        hi  = op[5:3];
        lo  = op[2:0];
        cls = CLS_ILLEGAL;
        case (op[7:6])
            2'b00: begin
                case (lo)
                    3'b000: begin
                        if (hi == 3'b000)      cls = CLS_NOP;
                        else if (hi != 3'b111) cls = CLS_INC;
                    end
                    3'b001: begin
                        if (hi == 3'b000)      cls = CLS_NOP;
                        else if (hi != 3'b111) cls = CLS_DCR;
                    end
                    3'b010:  if (!op[5]) cls = CLS_ROT;
                    3'b011:  cls = CLS_RETC;
                    3'b100:  cls = CLS_ALUI;
                    3'b101:  cls = CLS_RST;
                    3'b110:  cls = (hi == 3'b111) ? CLS_LMI : CLS_LRI;
                    default: cls = CLS_RET;
                endcase
            end
            2'b01: begin
                if (op[0]) begin
                    cls = (op[5:4] == 2'b00) ? CLS_INP : CLS_OUT;
                end else begin
                    case (op[2:1])
                        2'b00:   cls = CLS_JMPC;
                        2'b01:   cls = CLS_CALC;
                        2'b10:   cls = CLS_JMP;
                        default: cls = CLS_CAL;
                    endcase
                end
            end
            2'b10: cls = (lo == 3'b111) ? CLS_ALUM : CLS_ALUR;
            default: begin
                if (hi != 3'b111) cls = (lo == 3'b111) ? CLS_LRM : CLS_LRR;
                else              cls = (lo == 3'b111) ? CLS_HLT : CLS_LMR;
            end
        endcase
        if (cls == CLS_ILLEGAL && !illegal_en) cls = CLS_NOP;
        return cls;
    endfunction

    // Byte count of an instruction given its class.
    function automatic logic [1:0] inst_length(input inst_class_t cls);
        case (cls)
            CLS_ALUI, CLS_LRI, CLS_LMI:               return LEN_2;
            CLS_JMPC, CLS_CALC, CLS_JMP, CLS_CAL:     return LEN_3;
            default:                                  return LEN_1;
        endcase
    endfunction

endpackage

// File: rtl/cpu_byte_fifo.sv
// Prefetch byte queue: power-of-two depth, one push and one pop per cycle,
// synchronous flush.
module cpu_byte_fifo #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign dout    = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Byte storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cpu_fetch_decode.sv
// MCS8 fetch front end: queues fetched bytes, assembles 1/2/3-byte
// instructions and hands one classified record per handshake to execute.
module cpu_fetch_decode
    import cpu_fetch_decode_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int ILLEGAL_EN = 1
) (
    input  logic              CLK_I,
    input  logic              RSTn_I,
    input  logic [7:0]        BYTE_I,
    input  logic              BYTE_VLD_I,
    output logic              BYTE_RDY_O,
    input  logic              FLUSH_I,
    input  logic              RESUME_I,
    output logic              INST_VLD_O,
    input  logic              INST_RDY_I,
    output logic [4:0]        INST_CLASS_O,
    output logic [7:0]        INST_OP_O,
    output logic [7:0]        INST_IMM_O,
    output logic [ADDR_W-1:0] INST_ADDR_O,
    output logic [1:0]        INST_LEN_O,
    output logic              HALTED_O
);
    localparam int   CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic ILL_REP = (ILLEGAL_EN != 0);

    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             pop;
    logic             slot_free;

    asm_state_t       state;
    logic             halted;
    logic [7:0]       op_p0;
    logic [7:0]       b2_p0;
    inst_class_t      cls_in;
    inst_class_t      cls_p0;

    logic              vld_p1;
    inst_class_t       cls_p1;
    logic [7:0]        op_p1;
    logic [7:0]        imm_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [1:0]        len_p1;

    assign BYTE_RDY_O = (fifo_count != CNT_W'(FIFO_DEPTH)) & ~FLUSH_I;
    assign fifo_push  = BYTE_VLD_I & ~fifo_full & ~FLUSH_I;
    assign slot_free  = ~vld_p1 | INST_RDY_I;
    assign cls_in     = classify(fifo_dout, ILL_REP);
    assign cls_p0     = classify(op_p0, ILL_REP);

    cpu_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK_I),
        .rst_n (RSTn_I),
        .flush (FLUSH_I),
        .push  (fifo_push),
        .din   (BYTE_I),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pop one byte per cycle; opcodes wait for a free output slot, trailing bytes do not.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_OP:    pop = ~fifo_empty & slot_free;
            S_B2:    pop = ~fifo_empty;
            S_B3:    pop = ~fifo_empty;
            default: pop = 1'b0;
        endcase
        pop = pop & ~FLUSH_I;
    end

    // Assembler FSM and output record; flush clears the record but keeps a halt.
    always_ff @(posedge CLK_I or negedge RSTn_I) begin
        if (!RSTn_I) begin
            state   <= S_OP;
            halted  <= 1'b0;
            vld_p1  <= 1'b0;
            cls_p1  <= CLS_NOP;
            op_p1   <= '0;
            imm_p1  <= '0;
            addr_p1 <= '0;
            len_p1  <= '0;
        end else if (FLUSH_I) begin
            vld_p1  <= 1'b0;
            cls_p1  <= CLS_NOP;
            op_p1   <= '0;
            imm_p1  <= '0;
            addr_p1 <= '0;
            len_p1  <= '0;
            state   <= (state == S_HALT && !RESUME_I) ? S_HALT : S_OP;
            if (RESUME_I) halted <= 1'b0;
        end else begin
            if (vld_p1 && INST_RDY_I) vld_p1 <= 1'b0;
            case (state)
                S_OP: begin
                    if (pop) begin
                        if (inst_length(cls_in) == LEN_1) begin
                            vld_p1  <= 1'b1;
                            cls_p1  <= cls_in;
                            op_p1   <= fifo_dout;
                            imm_p1  <= '0;
                            addr_p1 <= '0;
                            len_p1  <= LEN_1;
                            if (cls_in == CLS_HLT) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end
                        end else begin
                            state <= S_B2;
                        end
                    end
                end
                S_B2: begin
                    if (pop) begin
                        if (inst_length(cls_p0) == LEN_2) begin
                            vld_p1  <= 1'b1;
                            cls_p1  <= cls_p0;
                            op_p1   <= op_p0;
                            imm_p1  <= fifo_dout;
                            addr_p1 <= '0;
                            len_p1  <= LEN_2;
                            state   <= S_OP;
                        end else begin
                            state <= S_B3;
                        end
                    end
                end
                S_B3: begin
                    if (pop) begin
                        vld_p1  <= 1'b1;
                        cls_p1  <= cls_p0;
                        op_p1   <= op_p0;
                        imm_p1  <= b2_p0;
                        addr_p1 <= {fifo_dout[ADDR_W-9:0], b2_p0};
                        len_p1  <= LEN_3;
                        state   <= S_OP;
                    end
                end
                default: begin
                    if (RESUME_I) begin
                        state  <= S_OP;
                        halted <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Partial-instruction byte latches; only read once the FSM has moved past them.
    always_ff @(posedge CLK_I) begin
        if (pop && state == S_OP) op_p0 <= fifo_dout;
        if (pop && state == S_B2) b2_p0 <= fifo_dout;
    end

    assign INST_VLD_O   = vld_p1;
    assign INST_CLASS_O = cls_p1;
    assign INST_OP_O    = op_p1;
    assign INST_IMM_O   = imm_p1;
    assign INST_ADDR_O  = addr_p1;
    assign INST_LEN_O   = len_p1;
    assign HALTED_O     = halted;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Directed bench for cpu_fetch_decode; a second instance with ILLEGAL_EN=0
// shares the stimulus for the undefined-opcode behaviour.
module tb_cpu_fetch_decode;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        byte_in;
    logic              byte_vld;
    logic              flush;
    logic              resume;
    logic              inst_rdy;

    logic              byte_rdy, inst_vld, halted;
    logic [4:0]        inst_class;
    logic [7:0]        inst_op, inst_imm;
    logic [ADDR_W-1:0] inst_addr;
    logic [1:0]        inst_len;

    logic              byte_rdy_b, inst_vld_b, halted_b;
    logic [4:0]        inst_class_b;
    logic [7:0]        inst_op_b, inst_imm_b;
    logic [ADDR_W-1:0] inst_addr_b;
    logic [1:0]        inst_len_b;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [4:0] cls;
        logic [7:0] op;
        logic [1:0] len;
    } rec_t;
    rec_t rec_log[$];

    always #5 clk = ~clk;

    cpu_fetch_decode #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .ILLEGAL_EN(1)) dut (
        .CLK_I(clk), .RSTn_I(rst_n), .BYTE_I(byte_in), .BYTE_VLD_I(byte_vld),
        .BYTE_RDY_O(byte_rdy), .FLUSH_I(flush), .RESUME_I(resume),
        .INST_VLD_O(inst_vld), .INST_RDY_I(inst_rdy), .INST_CLASS_O(inst_class),
        .INST_OP_O(inst_op), .INST_IMM_O(inst_imm), .INST_ADDR_O(inst_addr),
        .INST_LEN_O(inst_len), .HALTED_O(halted)
    );

    cpu_fetch_decode #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .ILLEGAL_EN(0)) dut_nop (
        .CLK_I(clk), .RSTn_I(rst_n), .BYTE_I(byte_in), .BYTE_VLD_I(byte_vld),
        .BYTE_RDY_O(byte_rdy_b), .FLUSH_I(flush), .RESUME_I(resume),
        .INST_VLD_O(inst_vld_b), .INST_RDY_I(inst_rdy), .INST_CLASS_O(inst_class_b),
        .INST_OP_O(inst_op_b), .INST_IMM_O(inst_imm_b), .INST_ADDR_O(inst_addr_b),
        .INST_LEN_O(inst_len_b), .HALTED_O(halted_b)
    );

    // Handshake log: a record sampled valid+ready here transfers on the next rising edge.
    always @(negedge clk) begin
        if (inst_vld && inst_rdy)
            rec_log.push_back('{cls: inst_class, op: inst_op, len: inst_len});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        byte_in  = b;
        byte_vld = 1'b1;
        #1;
        while (!byte_rdy && waited < 20) begin
            step();
            waited++;
        end
        if (waited >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: byte %h not accepted, ready=%b required 1", b, byte_rdy);
        end
        step();
        byte_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; byte_in = 8'h00; byte_vld = 1'b0;
        flush = 1'b0; resume = 1'b0; inst_rdy = 1'b0;
        step(); step();
        tests_run++;
        if ({inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len, halted} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0",
                     {inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len, halted});
        end
        tests_run++;
        if ({inst_vld_b, inst_class_b, inst_op_b, inst_imm_b, inst_addr_b, inst_len_b, halted_b} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs_nop: got %h required 0",
                     {inst_vld_b, inst_class_b, inst_op_b, inst_imm_b, inst_addr_b, inst_len_b, halted_b});
        end
        rst_n = 1'b1;
        step();
        tests_run++;
        if ({byte_rdy, byte_rdy_b, inst_vld, halted} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_release: rdy/rdy_b/vld/halted got %b required 1100",
                     {byte_rdy, byte_rdy_b, inst_vld, halted});
        end
    endtask

    task automatic test_lri();
        inst_rdy = 1'b1;
        rec_log.delete();
        push_byte(8'h06);
        push_byte(8'h55);
        tests_run++;
        if (inst_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL lri_latency: vld got %b required 0 at last push edge", inst_vld);
        end
        step();
        tests_run++;
        if ({inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len} !==
            {1'b1, 5'd8, 8'h06, 8'h55, 14'h0000, 2'd2}) begin
            tests_failed++;
            $display("FAIL lri_record: got %h required %h",
                     {inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len},
                     {1'b1, 5'd8, 8'h06, 8'h55, 14'h0000, 2'd2});
        end
        step(); step();
        tests_run++;
        if (rec_log.size() !== 1) begin
            tests_failed++;
            $display("FAIL lri_count: got %0d records required 1", rec_log.size());
        end
    endtask

    task automatic test_jmp();
        inst_rdy = 1'b1;
        rec_log.delete();
        push_byte(8'h44);
        push_byte(8'h34);
        push_byte(8'h12);
        step();
        tests_run++;
        if ({inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len} !==
            {1'b1, 5'd13, 8'h44, 8'h34, 14'h1234, 2'd3}) begin
            tests_failed++;
            $display("FAIL jmp_record: got %h required %h",
                     {inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len},
                     {1'b1, 5'd13, 8'h44, 8'h34, 14'h1234, 2'd3});
        end
        step(); step();
        tests_run++;
        if (rec_log.size() !== 1) begin
            tests_failed++;
            $display("FAIL jmp_count: got %0d records required 1", rec_log.size());
        end
    endtask

    task automatic test_back_to_back();
        int nvalid;
        int nbad;
        inst_rdy = 1'b0;
        byte_in  = 8'h80;
        byte_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (byte_rdy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_accept_%0d: ready got %b required 1", i, byte_rdy);
            end
            step();
        end
        tests_run++;
        if (byte_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_sixth_byte: ready got %b required 0", byte_rdy);
        end
        step(); step();
        tests_run++;
        if ({byte_rdy, inst_vld, inst_class, inst_op} !== {1'b0, 1'b1, 5'd17, 8'h80}) begin
            tests_failed++;
            $display("FAIL bp_hold: rdy/vld/class/op got %h required %h",
                     {byte_rdy, inst_vld, inst_class, inst_op}, {1'b0, 1'b1, 5'd17, 8'h80});
        end
        byte_vld = 1'b0;
        rec_log.delete();
        inst_rdy = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 5; i++) begin
            if (inst_vld === 1'b1) nvalid++;
            step();
        end
        tests_run++;
        if (nvalid !== 5 || inst_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_drain: valid cycles %0d then vld %b, required 5 then 0", nvalid, inst_vld);
        end
        nbad = 0;
        foreach (rec_log[i]) if (rec_log[i].cls !== 5'd17 || rec_log[i].op !== 8'h80) nbad++;
        tests_run++;
        if (rec_log.size() !== 5 || nbad !== 0) begin
            tests_failed++;
            $display("FAIL bp_records: got %0d records (%0d wrong) required 5 ALUR", rec_log.size(), nbad);
        end
    endtask

    task automatic test_halt();
        inst_rdy = 1'b1;
        rec_log.delete();
        push_byte(8'hFF);
        push_byte(8'hC1);
        tests_run++;
        if ({halted, inst_vld, inst_class, inst_op} !== {1'b1, 1'b1, 5'd1, 8'hFF}) begin
            tests_failed++;
            $display("FAIL halt_enter: halted/vld/class/op got %h required %h",
                     {halted, inst_vld, inst_class, inst_op}, {1'b1, 1'b1, 5'd1, 8'hFF});
        end
        step(); step(); step();
        tests_run++;
        if ({halted, inst_vld} !== 2'b10 || rec_log.size() !== 1) begin
            tests_failed++;
            $display("FAIL halt_stall: halted/vld %b records %0d, required 10 and 1",
                     {halted, inst_vld}, rec_log.size());
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        tests_run++;
        if (halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_resume: halted got %b required 0", halted);
        end
        step();
        tests_run++;
        if ({inst_vld, inst_class, inst_op, inst_len} !== {1'b1, 5'd19, 8'hC1, 2'd1}) begin
            tests_failed++;
            $display("FAIL halt_next: got %h required %h",
                     {inst_vld, inst_class, inst_op, inst_len}, {1'b1, 5'd19, 8'hC1, 2'd1});
        end
        step();
    endtask

    task automatic test_flush();
        inst_rdy = 1'b1;
        rec_log.delete();
        push_byte(8'h44);
        push_byte(8'h34);
        flush    = 1'b1;
        byte_in  = 8'h12;
        byte_vld = 1'b1;
        #1;
        tests_run++;
        if (byte_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_rdy: ready got %b required 0", byte_rdy);
        end
        step();
        flush    = 1'b0;
        byte_vld = 1'b0;
        step(); step();
        tests_run++;
        if (inst_vld !== 1'b0 || rec_log.size() !== 0) begin
            tests_failed++;
            $display("FAIL flush_discard: vld %b records %0d, required 0 and 0", inst_vld, rec_log.size());
        end
        push_byte(8'hC1);
        step();
        tests_run++;
        if ({inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len} !==
            {1'b1, 5'd19, 8'hC1, 8'h00, 14'h0000, 2'd1}) begin
            tests_failed++;
            $display("FAIL flush_next: got %h required %h",
                     {inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len},
                     {1'b1, 5'd19, 8'hC1, 8'h00, 14'h0000, 2'd1});
        end
        step();
        // held record is dropped by a flush
        inst_rdy = 1'b0;
        push_byte(8'h00);
        step();
        tests_run++;
        if ({inst_vld, inst_class, inst_op} !== {1'b1, 5'd0, 8'h00}) begin
            tests_failed++;
            $display("FAIL flush_held_pre: got %h required %h", {inst_vld, inst_class, inst_op}, {1'b1, 5'd0, 8'h00});
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        inst_rdy = 1'b1;
        step();
        tests_run++;
        if (inst_vld !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_held_clear: vld got %b required 0", inst_vld);
        end
    endtask

    task automatic test_flush_halt();
        inst_rdy = 1'b1;
        push_byte(8'hFF);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        tests_run++;
        if (halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_in_halt: halted got %b required 1", halted);
        end
        push_byte(8'hC1);
        step(); step();
        tests_run++;
        if ({halted, inst_vld} !== 2'b10) begin
            tests_failed++;
            $display("FAIL halt_queue: halted/vld got %b required 10", {halted, inst_vld});
        end
        flush  = 1'b1;
        resume = 1'b1;
        step();
        flush  = 1'b0;
        resume = 1'b0;
        step(); step();
        tests_run++;
        if ({halted, inst_vld} !== 2'b00) begin
            tests_failed++;
            $display("FAIL flush_resume: halted/vld got %b required 00", {halted, inst_vld});
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ops [3];
        logic [4:0] exp_a [3];
        logic [4:0] exp_b [3];
        ops[0] = 8'h38; exp_a[0] = 5'd31; exp_b[0] = 5'd0;
        ops[1] = 8'h2A; exp_a[1] = 5'd31; exp_b[1] = 5'd0;
        ops[2] = 8'h0A; exp_a[2] = 5'd4;  exp_b[2] = 5'd4;
        inst_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_byte(ops[i]);
            step();
            tests_run++;
            if ({inst_vld, inst_class, inst_op, inst_len} !== {1'b1, exp_a[i], ops[i], 2'd1}) begin
                tests_failed++;
                $display("FAIL illegal_en1_%h: got %h required %h", ops[i],
                         {inst_vld, inst_class, inst_op, inst_len}, {1'b1, exp_a[i], ops[i], 2'd1});
            end
            tests_run++;
            if ({inst_vld_b, inst_class_b, inst_op_b, inst_len_b} !== {1'b1, exp_b[i], ops[i], 2'd1}) begin
                tests_failed++;
                $display("FAIL illegal_en0_%h: got %h required %h", ops[i],
                         {inst_vld_b, inst_class_b, inst_op_b, inst_len_b}, {1'b1, exp_b[i], ops[i], 2'd1});
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        inst_rdy = 1'b1;
        rec_log.delete();
        push_byte(8'h46);
        push_byte(8'h10);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len, halted} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs: got %h required 0",
                     {inst_vld, inst_class, inst_op, inst_imm, inst_addr, inst_len, halted});
        end
        step();
        rst_n = 1'b1;
        step(); step(); step();
        tests_run++;
        if (inst_vld !== 1'b0 || rec_log.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_norec: vld %b records %0d, required 0 and 0", inst_vld, rec_log.size());
        end
        push_byte(8'h20);
        step();
        tests_run++;
        if ({inst_vld, inst_class, inst_op, inst_len} !== {1'b1, 5'd2, 8'h20, 2'd1}) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got %h required %h",
                     {inst_vld, inst_class, inst_op, inst_len}, {1'b1, 5'd2, 8'h20, 2'd1});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_lri();
        test_jmp();
        test_back_to_back();
        test_halt();
        test_flush();
        test_flush_halt();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_decode.md
Name: cpu_fetch_decode

Overview:
MCS8 instruction fetch/assembly front end with a parametrised prefetch queue. It accepts opcode and operand bytes from the memory interface and buffers them in a byte FIFO of configurable depth. It then assembles complete 1-, 2- or 3-byte instructions, classifies each opcode and presents one registered instruction record per handshake to the execute stage. It also supports pipeline flush (for taken jumps, calls and returns) and a halt/resume mode.

Parameters:
ADDR_W, 14, width of the assembled jump/call address: {byte3[ADDR_W-9:0], byte2}; legal range 9..16
FIFO_DEPTH, 4, prefetch byte queue depth; power of two, minimum 2
ILLEGAL_EN, 1, 1: undefined opcodes flagged as class ILLEGAL; 0: undefined opcodes reported as NOP

Ports:
CLK_I  in  1  clock, all state on rising edge
RSTn_I  in  1  asynchronous active-low reset
BYTE_I  in  8  fetched byte
BYTE_VLD_I  in  1  BYTE_I valid
BYTE_RDY_O  out  1  queue can accept; byte transferred when VLD&RDY
FLUSH_I  in  1  discard queue, partial instruction and pending output
RESUME_I  in  1  leave halted state
INST_VLD_O  out  1  instruction record valid
INST_RDY_I  in  1  execute stage accepts record
INST_CLASS_O  out  5  class code (see package)
INST_OP_O  out  8  opcode byte
INST_IMM_O  out  8  byte 2 (0 for 1-byte instructions)
INST_ADDR_O  out  ADDR_W  assembled address (0 unless 3-byte)
INST_LEN_O  out  2  1, 2 or 3
HALTED_O  out  1  halted state indicator

Behaviour:
- Reset (async assert, sync release): FIFO empty; assembler in S_OP; every output register is 0. HALTED_O=0. BYTE_RDY_O=1 from the first edge after release.
- FIFO:
  - BYTE_RDY_O = (count != FIFO_DEPTH) & ~FLUSH_I.
  - Push and pop in the same cycle are allowed when neither full nor empty.
  - Pointers wrap modulo FIFO_DEPTH. Count is $clog2(FIFO_DEPTH)+1 bits wide.
- Classification of the opcode byte op:
  - NOP 0000000x; HLT 11111111; INC 00DDD000 with DDD not 000/111; DCR 00DDD001 with DDD not 000/111; ROT 000xx010; RETC 00CCC011; ALUI 00PPP100; RST 00AAA101; LRI 00DDD110 with DDD!=111; LMI 00111110; RET 00xxx111.
  - JMPC 01CCC000; CALC 01CCC010; JMP 01xxx100; CAL 01xxx110; INP 0100MMM1; OUT 01RRMMM1 with RR!=00.
  - ALUR 10PPPSSS with SSS!=111; ALUM 10PPP111; LRR 11DDDSSS with DDD!=111 and SSS!=111; LRM 11DDD111 with DDD!=111; LMR 11111SSS with SSS!=111.
  - All other opcodes (e.g. 0x38, 0x39, 0x2A) are ILLEGAL.
- Length: 2 bytes for ALUI/LRI/LMI; 3 bytes for JMPC/CALC/JMP/CAL; 1 byte otherwise, including ILLEGAL.
- Assembler FSM, states S_OP, S_B2, S_B3, S_HALT:
  - S_OP: pops an opcode when FIFO is non-empty and the output slot is free (~INST_VLD_O | INST_RDY_I). For a 1-byte opcode it loads the output record the same edge; otherwise it latches the opcode and goes to S_B2.
  - S_B2: pops byte 2 when non-empty. For a 2-byte instruction it loads the record and returns to S_OP; for a 3-byte instruction it goes to S_B3.
  - S_B3: pops byte 3, loads the record, returns to S_OP.
  - At most one byte is popped per cycle.
- Latency: a byte pushed at edge t is poppable at edge t+1. The record is valid after edge t+1 from the last byte's push, provided the slot is free.
- Output record is held stable while INST_VLD_O & ~INST_RDY_I.
- HLT:
  - When the HLT record is loaded, the FSM enters S_HALT and HALTED_O=1 on the same edge.
  - In S_HALT no pops occur; the FIFO still accepts bytes until full.
  - RESUME_I for one cycle returns the FSM to S_OP and clears HALTED_O.
- FLUSH_I (1 cycle):
  - Empties the FIFO, clears INST_VLD_O and returns the FSM to S_OP, all on the next edge.
  - Any byte offered that cycle is not accepted.
  - If INST_RDY_I is also high, the handshake still completes, then the record is cleared.
  - Flush does not exit S_HALT.
  - RESUME_I together with FLUSH_I: both take effect.
- Reset mid-instruction discards all partial state; no record is emitted.

Decomposition:
- Shared include cpu_defs.vh holds:
  - class code constants: NOP=0, HLT=1, INC=2, DCR=3, ROT=4, RETC=5, ALUI=6, RST=7, LRI=8, LMI=9, RET=10, JMPC=11, CALC=12, JMP=13, CAL=14, INP=15, OUT=16, ALUR=17, ALUM=18, LRR=19, LRM=20, LMR=21, ILLEGAL=31;
  - FSM state codes;
  - the length encoding.
- One sub-module, cpu_byte_fifo (parameter DEPTH), provides push/pop/count/full/empty.
- Classification is combinational logic inside cpu_fetch_decode.

Test Plan:
- Push 0x06, 0x55 with INST_RDY_I=1 -> one record: CLASS=LRI(8), OP=0x06, IMM=0x55, LEN=2, ADDR=0.
- Push 0x44, 0x34, 0x12 (ADDR_W=14) -> CLASS=JMP(13), IMM=0x34, ADDR=0x1234, LEN=3.
- INST_RDY_I=0, FIFO_DEPTH=4, push 0x80 continuously -> one record held (ALUR), 4 bytes queued, BYTE_RDY_O=0 at the 6th byte. Then release INST_RDY_I -> 5 ALUR records back-to-back, one per cycle.
- Push 0xFF, 0xC1 -> HLT record, HALTED_O=1, 0xC1 stays queued. Pulse RESUME_I -> LRR(19) record, HALTED_O=0.
- Push 0x44, 0x34, pulse FLUSH_I, then push 0xC1 -> no JMP record ever. Next record is LRR, OP=0xC1, LEN=1.
- Push 0x38 with ILLEGAL_EN=1 -> CLASS=31, LEN=1. Same stimulus with ILLEGAL_EN=0 -> CLASS=NOP(0). Assert RSTn_I low between bytes 2 and 3 of 0x46 -> all outputs 0 and no record emitted.
